fpa_result_fifo: RTL and testbench
==================================

FPA_RESULT_FIFO -- requirements
Module: fpa_result_fifo

Interface
REQ-001 Parameter W, 32, data width; matches the single-precision FPA result width.
REQ-002 Parameter DEPTH, 4, number of entries; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Result  input  W  FPA result word; valid whenever Done is high.
REQ-006 Done  input  1  FPA completion; may stay high for several cycles.
REQ-007 ovf_flag  input  1  FPA overflow indication; sampled together with Result.
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 rd_data  output  W  head entry result, first-word-fall-through.
REQ-010 rd_ovf  output  1  head entry overflow bit.
REQ-011 valid  output  1  FIFO not empty.
REQ-012 full  output  1  count equals DEPTH.
REQ-013 count  output  $clog2(DEPTH+1)  occupied entries.
REQ-014 drop_flag  output  1  sticky; a result was lost because the FIFO was full.
REQ-015 res_class  output  3  head classification {nan, inf, zero}.

Function
REQ-016 The block SHALL register Done into done_d and detect done_rise = Done & ~done_d.
REQ-017 Each done_rise SHALL produce exactly one push attempt of {ovf_flag, Result}, sampled in that same cycle.
REQ-018 Done held high after a rise SHALL NOT produce further pushes.
REQ-019 A pop SHALL occur on a clock edge when rd_en & valid; rd_en while empty SHALL be ignored, with no state change.
REQ-020 A push SHALL occur when done_rise and (not full, or a pop occurs in the same cycle).
REQ-021 Simultaneous push and pop SHALL leave count unchanged and be legal at count 0 only if the push is not read in the same cycle: when empty, the pop is ignored and the push proceeds.
REQ-022 done_rise while full without a pop SHALL discard the result, leave the contents intact, and set drop_flag until reset.
REQ-023 Write and read pointers SHALL be log2(DEPTH) bits, increment by one per operation, and wrap DEPTH-1 -> 0.
REQ-024 rd_data and rd_ovf SHALL reflect the head entry combinationally from storage; their value is don't-care while valid = 0.
REQ-025 Latency SHALL be one cycle: data pushed at edge N is visible with valid = 1 after edge N.
REQ-026 valid, full and count SHALL be registered-state derived, with no combinational path from rd_en or Done.

Reset
REQ-027 While reset is high, the block SHALL immediately clear the pointers, count, done_d, drop_flag and storage to 0, giving valid = 0, full = 0, rd_data = 0, rd_ovf = 0 and res_class = 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries and any in-flight push.
REQ-029 Done already high in the first cycle after reset release SHALL count as a rising edge.

Configuration
REQ-030 With FPA_CLASSIFY_EN defined, res_class SHALL decode rd_data as follows:
- zero: exponent 0 and mantissa 0.
- inf: exponent 255 and mantissa 0.
- nan: exponent 255 and mantissa non-zero.
- All three bits SHALL be 0 while valid = 0.
REQ-031 Without FPA_CLASSIFY_EN, res_class SHALL remain a port, tied to 3'b000, with no classification logic synthesized.

Structure
REQ-032 A shared package fpa_pkg SHALL hold:
- the W default;
- exponent and mantissa field bit ranges (30:23, 22:0);
- the exponent all-ones constant 8'hFF;
- the class bit indices.
REQ-033 The classifier SHALL be one combinational sub-module, fpa_classify, instantiated only under FPA_CLASSIFY_EN.
REQ-034 Storage SHALL be a flop array of DEPTH x (W+1) bits; no RAM macro.

Verification
REQ-035 Done pulses 1 cycle with Result=32'h3F800000 and ovf_flag=0 -> next cycle valid=1, rd_data=32'h3F800000, count=1, res_class=000.
REQ-036 Done held high 5 cycles with Result=32'h40000000 -> count=1 only; a pop returns 32'h40000000, then valid=0.
REQ-037 Four Done pulses (32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h3F800000) with no reads -> full=1; the head reads out in order with res_class 001, 010, 100, 000 (FPA_CLASSIFY_EN defined); a fifth pulse sets drop_flag=1 and the contents are unchanged.
REQ-038 FIFO full with done_rise and rd_en in the same cycle -> count stays 4, the oldest entry is popped, the new entry lands at the tail, drop_flag stays 0; 10 further push/pop pairs exercise pointer wrap.
REQ-039 Reset asserted asynchronously mid-clock with count=3 and drop_flag=1 -> all outputs 0 before the next edge; rd_en while empty changes nothing.
REQ-040 Build without FPA_CLASSIFY_EN and rerun REQ-037 -> res_class constant 000, data ordering identical.

Source files
------------

// File: rtl/fpa_pkg.sv
// fpa_pkg: shared constants for the FPA result path.
// Holds the default result width, the single-precision exponent/mantissa
// field ranges, the all-ones exponent code, the res_class bit indices and
// a helper that classifies a result word from its exponent and mantissa.
package fpa_pkg;

  localparam int unsigned FPA_W = 32;

  // Single-precision field ranges
  localparam int unsigned EXP_HI = 30;
  localparam int unsigned EXP_LO = 23;
  localparam int unsigned MAN_HI = 22;
  localparam int unsigned MAN_LO = 0;
  localparam int unsigned EXP_W  = EXP_HI - EXP_LO + 1;
  localparam int unsigned MAN_W  = MAN_HI - MAN_LO + 1;

  localparam logic [EXP_W-1:0] EXP_ONES = 8'hFF;

  // res_class bit positions: {nan, inf, zero}
  localparam int unsigned CLASS_W    = 3;
  localparam int unsigned CLASS_ZERO = 0;
  localparam int unsigned CLASS_INF  = 1;
  localparam int unsigned CLASS_NAN  = 2;

  // Classify exponent+mantissa; the sign bit does not affect the class.
  function automatic logic [CLASS_W-1:0] classify_word(input logic [EXP_HI:0] mag);
    logic [EXP_W-1:0]   exp_f;
    logic [MAN_W-1:0]   man_f;
    logic [CLASS_W-1:0] cls;
    exp_f = mag[EXP_HI:EXP_LO];
    man_f = mag[MAN_HI:MAN_LO];
    cls   = '0;
    cls[CLASS_ZERO] = (exp_f == '0)       && (man_f == '0);
    cls[CLASS_INF]  = (exp_f == EXP_ONES) && (man_f == '0);
    cls[CLASS_NAN]  = (exp_f == EXP_ONES) && (man_f != '0);
    return cls;
  endfunction

endpackage

// File: rtl/fpa_result_fifo_if.sv
// fpa_result_fifo_if: producer/consumer bundle for fpa_result_fifo.
// Producer side: Result, Done, ovf_flag. Consumer side: rd_en in;
// rd_data, rd_ovf, valid, full, count, drop_flag, res_class out.
// master = the environment driving the FIFO, slave = the FIFO itself.
interface fpa_result_fifo_if
  import fpa_pkg::*;
#(
  parameter int unsigned W     = FPA_W,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]       Result;
  logic               Done;
  logic               ovf_flag;
  logic               rd_en;
  logic [W-1:0]       rd_data;
  logic               rd_ovf;
  logic               valid;
  logic               full;
  logic [CNT_W-1:0]   count;
  logic               drop_flag;
  logic [CLASS_W-1:0] res_class;

  modport master (
    output Result, Done, ovf_flag, rd_en,
    input  rd_data, rd_ovf, valid, full, count, drop_flag, res_class
  );

  modport slave (
    input  Result, Done, ovf_flag, rd_en,
    output rd_data, rd_ovf, valid, full, count, drop_flag, res_class
  );

endinterface

// File: rtl/fpa_classify.sv
// fpa_classify: combinational {nan, inf, zero} decode of the FIFO head.
// Ports: mag (exponent+mantissa of head word), valid (FIFO not empty),
// cls_c (class bits, forced to zero while valid is low).
// Only built when FPA_CLASSIFY_EN is defined.
`ifdef FPA_CLASSIFY_EN
module fpa_classify
  import fpa_pkg::*;
(
  input  logic [EXP_HI:0]    mag,
  input  logic               valid,
  output logic [CLASS_W-1:0] cls_c
);

  always_comb begin
    cls_c = '0;
    if (valid) cls_c = classify_word(mag);
  end

endmodule
`endif

// File: rtl/fpa_result_fifo.sv
// fpa_result_fifo: captures one FPA result per rising edge of Done into a
// first-word-fall-through FIFO of DEPTH entries ({ovf_flag, Result}).
// Ports: clk, reset (async, active-high), bus (fpa_result_fifo_if.slave).
// Optional macro FPA_CLASSIFY_EN enables head classification on res_class;
// without it res_class is tied to 3'b000.
module fpa_result_fifo
  import fpa_pkg::*;
#(
  parameter int unsigned W     = FPA_W,
  parameter int unsigned DEPTH = 4
)(
  input  logic              clk,
  input  logic              reset,
  fpa_result_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             full_q;
  logic             done_d;
  logic             drop_q;

  logic             done_rise_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic [CNT_W-1:0] count_nxt_c;

  // Handshake decode; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    done_rise_c = bus.Done & ~done_d;
    pop_c       = bus.rd_en & valid_q;
    push_c      = done_rise_c & (~full_q | pop_c);
    drop_c      = done_rise_c & full_q & ~pop_c;
    count_nxt_c = count_q;
    if (push_c && !pop_c)      count_nxt_c = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_nxt_c = count_q - CNT_W'(1);
  end

  // State, storage and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      done_d  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      done_d <= bus.Done;
      if (push_c) begin
        mem[wr_ptr] <= {bus.ovf_flag, bus.Result};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_nxt_c;
      valid_q <= (count_nxt_c != '0);
      full_q  <= (count_nxt_c == CNT_W'(DEPTH));
      if (drop_c) drop_q <= 1'b1;
    end
  end

  // Head entry falls through straight from storage
  assign bus.rd_data   = mem[rd_ptr][W-1:0];
  assign bus.rd_ovf    = mem[rd_ptr][W];
  assign bus.valid     = valid_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.drop_flag = drop_q;

`ifdef FPA_CLASSIFY_EN
  logic [CLASS_W-1:0] cls_c;

  fpa_classify u_classify (
    .mag   (bus.rd_data[EXP_HI:0]),
    .valid (valid_q),
    .cls_c (cls_c)
  );

  assign bus.res_class = cls_c;
`else
  assign bus.res_class = 3'b000;
`endif

endmodule

// File: tb/tb_fpa_result_fifo.sv
// tb_fpa_result_fifo: self-checking bench for fpa_result_fifo with a
// queue-based reference model; directed scenarios plus random traffic.
module tb_fpa_result_fifo;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpa_result_fifo_if #(.W(32), .DEPTH(DEPTH)) bus ();

  fpa_result_fifo #(.W(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue of {ovf, result}, sticky drop, previous Done
  logic [32:0] mq[$];
  logic        m_drop;
  logic        m_prev;

  function automatic logic [2:0] exp_class(input logic [31:0] d, input bit nonempty);
`ifdef FPA_CLASSIFY_EN
    logic [7:0]  e;
    logic [22:0] m;
    e = d[30:23];
    m = d[22:0];
    if (!nonempty) return 3'b000;
    if (e == 8'h00 && m == 23'd0) return 3'b001;
    if (e == 8'hFF) return (m == 23'd0) ? 3'b010 : 3'b100;
    return 3'b000;
`else
    if (nonempty || d[0]) return 3'b000;
    return 3'b000;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drop = 1'b0;
    m_prev = 1'b0;
  endtask

  task automatic model_step(input logic d, input logic [31:0] r, input logic o, input logic re);
    if (re && mq.size() > 0) void'(mq.pop_front());
    if (d && !m_prev) begin
      if (mq.size() < int'(DEPTH)) mq.push_back({o, r});
      else m_drop = 1'b1;
    end
    m_prev = d;
  endtask

  // One clock: drive at negedge, model at posedge, settle 1ns after
  task automatic drive(input logic d, input logic [31:0] r, input logic o, input logic re);
    @(negedge clk);
    bus.Done = d; bus.Result = r; bus.ovf_flag = o; bus.rd_en = re;
    @(posedge clk);
    model_step(d, r, o, re);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.Done = 1'b0; bus.Result = '0; bus.ovf_flag = 1'b0; bus.rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.Done = 1'b0; bus.Result = '0; bus.ovf_flag = 1'b0; bus.rd_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    vectors++; if (bus.drop_flag !== 1'b0) begin miscompares++; $display("FAIL reset_drop: got %b expected 0", bus.drop_flag); end
    vectors++; if (bus.rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
    vectors++; if (bus.rd_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_rd_ovf: got %b expected 0", bus.rd_ovf); end
    vectors++; if (bus.res_class !== 3'b000) begin miscompares++; $display("FAIL reset_class: got %b expected 000", bus.res_class); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_pulse();
    drive(1'b1, 32'h3F800000, 1'b0, 1'b0);
    vectors++; if (bus.valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b expected 1", bus.valid); end
    vectors++; if (bus.rd_data !== 32'h3F800000) begin miscompares++; $display("FAIL single_data: got %h expected 3f800000", bus.rd_data); end
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", bus.count); end
    vectors++; if (bus.res_class !== 3'b000) begin miscompares++; $display("FAIL single_class: got %b expected 000", bus.res_class); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL single_pop_valid: got %b expected 0", bus.valid); end
  endtask

  task automatic test_held_done();
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h40000000, 1'b0, 1'b0);
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL held_count: got %0d expected 1", bus.count); end
    vectors++; if (bus.rd_data !== 32'h40000000) begin miscompares++; $display("FAIL held_data: got %h expected 40000000", bus.rd_data); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL held_pop_valid: got %b expected 0", bus.valid); end
  endtask

  task automatic test_fill_and_drop();
    logic [31:0] vals [4];
    logic [2:0]  cls  [4];
    vals[0] = 32'h00000000; vals[1] = 32'h7F800000; vals[2] = 32'h7FC00000; vals[3] = 32'h3F800000;
`ifdef FPA_CLASSIFY_EN
    cls[0] = 3'b001; cls[1] = 3'b010; cls[2] = 3'b100; cls[3] = 3'b000;
`else
    cls[0] = 3'b000; cls[1] = 3'b000; cls[2] = 3'b000; cls[3] = 3'b000;
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      drive(1'b0, vals[i], 1'b0, 1'b0);
    end
    vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b expected 1", bus.full); end
    vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d expected 4", bus.count); end
    vectors++; if (bus.drop_flag !== 1'b0) begin miscompares++; $display("FAIL fill_drop_early: got %b expected 0", bus.drop_flag); end
    drive(1'b1, 32'h12345678, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++; if (bus.drop_flag !== 1'b1) begin miscompares++; $display("FAIL drop_flag: got %b expected 1", bus.drop_flag); end
    vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL drop_count: got %0d expected 4", bus.count); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.rd_data !== vals[i]) begin miscompares++; $display("FAIL drain_data[%0d]: got %h expected %h", i, bus.rd_data, vals[i]); end
      vectors++; if (bus.res_class !== cls[i]) begin miscompares++; $display("FAIL drain_class[%0d]: got %b expected %b", i, bus.res_class, cls[i]); end
      vectors++; if (bus.rd_ovf !== 1'b0) begin miscompares++; $display("FAIL drain_ovf[%0d]: got %b expected 0", i, bus.rd_ovf); end
      drive(1'b0, 32'h0, 1'b0, 1'b1);
    end
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty: got %b expected 0", bus.valid); end
    vectors++; if (bus.res_class !== 3'b000) begin miscompares++; $display("FAIL drain_empty_class: got %b expected 000", bus.res_class); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] fill [4];
    logic [31:0] r;
    logic        o;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      fill[i] = $urandom;
      drive(1'b1, fill[i], 1'(i & 1), 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
    end
    r = $urandom;
    drive(1'b1, r, 1'b1, 1'b1);
    vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL pp_count: got %0d expected 4", bus.count); end
    vectors++; if (bus.drop_flag !== 1'b0) begin miscompares++; $display("FAIL pp_drop: got %b expected 0", bus.drop_flag); end
    vectors++; if (bus.rd_data !== fill[1]) begin miscompares++; $display("FAIL pp_head: got %h expected %h", bus.rd_data, fill[1]); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      r = $urandom; o = 1'($urandom_range(0, 1));
      drive(1'b1, r, o, 1'b1);
      vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL wrap_count[%0d]: got %0d expected 4", i, bus.count); end
      vectors++; if ({bus.rd_ovf, bus.rd_data} !== mq[0]) begin miscompares++; $display("FAIL wrap_head[%0d]: got %h expected %h", i, {bus.rd_ovf, bus.rd_data}, mq[0]); end
    end
    vectors++; if (bus.drop_flag !== 1'b0) begin miscompares++; $display("FAIL wrap_drop: got %b expected 0", bus.drop_flag); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    while (mq.size() > 0) begin
      vectors++; if ({bus.rd_ovf, bus.rd_data} !== mq[0]) begin miscompares++; $display("FAIL wrap_drain: got %h expected %h", {bus.rd_ovf, bus.rd_data}, mq[0]); end
      drive(1'b0, 32'h0, 1'b0, 1'b1);
    end
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty: got %b expected 0", bus.valid); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h3F800000 + 32'(i), 1'b1, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL pre_rst_count: got %0d expected 3", bus.count); end
    vectors++; if (bus.drop_flag !== 1'b1) begin miscompares++; $display("FAIL pre_rst_drop: got %b expected 1", bus.drop_flag); end
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
    #1;
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b expected 0", bus.valid); end
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL arst_count: got %0d expected 0", bus.count); end
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL arst_full: got %b expected 0", bus.full); end
    vectors++; if (bus.drop_flag !== 1'b0) begin miscompares++; $display("FAIL arst_drop: got %b expected 0", bus.drop_flag); end
    vectors++; if (bus.rd_data !== 32'h0) begin miscompares++; $display("FAIL arst_data: got %h expected 0", bus.rd_data); end
    vectors++; if (bus.rd_ovf !== 1'b0) begin miscompares++; $display("FAIL arst_ovf: got %b expected 0", bus.rd_ovf); end
    vectors++; if (bus.res_class !== 3'b000) begin miscompares++; $display("FAIL arst_class: got %b expected 000", bus.res_class); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL empty_rd_valid: got %b expected 0", bus.valid); end
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL empty_rd_count: got %0d expected 0", bus.count); end
    vectors++; if (bus.rd_data !== 32'h0) begin miscompares++; $display("FAIL empty_rd_data: got %h expected 0", bus.rd_data); end
    // Done already high when reset releases must push
    @(negedge clk);
    reset = 1'b1;
    bus.Done = 1'b1; bus.Result = 32'h7F800000; bus.ovf_flag = 1'b1; bus.rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_step(1'b1, 32'h7F800000, 1'b1, 1'b0);
    #1;
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL rel_count: got %0d expected 1", bus.count); end
    vectors++; if (bus.rd_data !== 32'h7F800000) begin miscompares++; $display("FAIL rel_data: got %h expected 7f800000", bus.rd_data); end
    vectors++; if (bus.rd_ovf !== 1'b1) begin miscompares++; $display("FAIL rel_ovf: got %b expected 1", bus.rd_ovf); end
    drive(1'b1, 32'h7F800000, 1'b1, 1'b0);
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL rel_hold_count: got %0d expected 1", bus.count); end
  endtask

  task automatic test_random();
    logic [31:0] specials [5];
    logic [31:0] r;
    logic        d, o, re;
    logic [2:0]  ecnt;
    specials[0] = 32'h00000000; specials[1] = 32'hFF800000; specials[2] = 32'h7F800001;
    specials[3] = 32'h80000000; specials[4] = 32'h3F800000;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      d  = ($urandom_range(0, 2) != 0);
      re = ($urandom_range(0, 2) == 0);
      o  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      drive(d, r, o, re);
      ecnt = 3'(mq.size());
      vectors++; if (bus.count !== ecnt) begin miscompares++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, bus.count, ecnt); end
      vectors++; if (bus.valid !== (mq.size() > 0)) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.valid, mq.size() > 0); end
      vectors++; if (bus.full !== (mq.size() == int'(DEPTH))) begin miscompares++; $display("FAIL rnd_full[%0d]: got %b", i, bus.full); end
      vectors++; if (bus.drop_flag !== m_drop) begin miscompares++; $display("FAIL rnd_drop[%0d]: got %b expected %b", i, bus.drop_flag, m_drop); end
      if (mq.size() > 0) begin
        vectors++; if ({bus.rd_ovf, bus.rd_data} !== mq[0]) begin miscompares++; $display("FAIL rnd_head[%0d]: got %h expected %h", i, {bus.rd_ovf, bus.rd_data}, mq[0]); end
        vectors++; if (bus.res_class !== exp_class(mq[0][31:0], 1'b1)) begin miscompares++; $display("FAIL rnd_class[%0d]: got %b expected %b", i, bus.res_class, exp_class(mq[0][31:0], 1'b1)); end
      end else begin
        vectors++; if (bus.res_class !== 3'b000) begin miscompares++; $display("FAIL rnd_class_empty[%0d]: got %b expected 000", i, bus.res_class); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_held_done();
    test_fill_and_drop();
    test_full_push_pop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
